// File: rtl/pwm_capture.sv
// pwm_capture: recovers the duty reference of an incoming PWM waveform.
// The input is synchronized and then sampled once per sample tick. The
// number of high ticks between two rising edges is the recovered duty.
// A frame is PERIOD ticks long; frames of any other length are rejected.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-low reset
//   pwm_in     asynchronous PWM input
//   duty_out   last recovered duty value, held between updates
//   duty_valid one-clk pulse when duty_out updates
//   frame_err  one-clk pulse when a frame is rejected
//   stuck_high level flag, input held high for 2*PERIOD ticks
//   locked     level flag, high while measuring frames
module pwm_capture #(
  parameter int DIV    = 4,
  parameter int WIDTH  = 5,
  parameter int PERIOD = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] duty_out,
  output logic             duty_valid,
  output logic             frame_err,
  output logic             stuck_high,
  output logic             locked
);

  localparam int CW = WIDTH + 2;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic {SEEK, MEASURE} state_t;

  state_t           state, state_nxt;
  logic             sync_p0, sync_p1, prev_p2;
  logic [DW-1:0]    div_cnt;
  logic             tick, s, rise;
  logic [CW-1:0]    total_cnt, high_cnt, total_nxt, high_nxt, total_inc;
  logic [WIDTH-1:0] duty_nxt;
  logic             valid_nxt, err_nxt, stuck_nxt;

  // High-tick count never exceeds PERIOD, whatever the input does.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic b);
    if (b && (v < CW'(PERIOD)))
      return v + CW'(1);
    return v;
  endfunction

  assign tick      = (div_cnt == DW'(DIV - 1));
  assign s         = sync_p1;
  assign rise      = s & ~prev_p2;
  assign total_inc = total_cnt + CW'(1);
  assign locked    = (state == MEASURE);

  always_comb begin
    state_nxt = state;
    total_nxt = total_cnt;
    high_nxt  = high_cnt;
    duty_nxt  = duty_out;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    stuck_nxt = stuck_high;
    if (tick) begin
      if (rise) begin
        // An edge always wins over a coinciding timeout.
        state_nxt = MEASURE;
        total_nxt = CW'(1);
        high_nxt  = CW'(1);
        stuck_nxt = 1'b0;
        if (state == MEASURE) begin
          if ((total_cnt == CW'(PERIOD)) && (high_cnt <= CW'(PERIOD - 1))) begin
            duty_nxt  = high_cnt[WIDTH-1:0];
            valid_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end else if (total_inc == CW'(2 * PERIOD)) begin
        // No edge for two frames: constant low is a legal duty of 0,
        // constant high is a stuck input.
        state_nxt = SEEK;
        total_nxt = '0;
        high_nxt  = '0;
        if (s) begin
          stuck_nxt = 1'b1;
          err_nxt   = 1'b1;
        end else begin
          duty_nxt  = '0;
          valid_nxt = 1'b1;
        end
      end else begin
        total_nxt = total_inc;
        if (state == MEASURE)
          high_nxt = sat_inc(high_cnt, s);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_p0    <= 1'b0;
      sync_p1    <= 1'b0;
      prev_p2    <= 1'b0;
      div_cnt    <= '0;
      state      <= SEEK;
      total_cnt  <= '0;
      high_cnt   <= '0;
      duty_out   <= '0;
      duty_valid <= 1'b0;
      frame_err  <= 1'b0;
      stuck_high <= 1'b0;
    end else begin
      // Stage p0/p1: two-flop synchronizer
      sync_p0 <= pwm_in;
      sync_p1 <= sync_p0;
      // Stage p2: per-tick sample history and frame measurement
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      if (tick)
        prev_p2 <= sync_p1;
      state      <= state_nxt;
      total_cnt  <= total_nxt;
      high_cnt   <= high_nxt;
      duty_out   <= duty_nxt;
      duty_valid <= valid_nxt;
      frame_err  <= err_nxt;
      stuck_high <= stuck_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture: drives tick-aligned PWM levels, queues the
// expected duty_valid / frame_err pulses and checks them in a separate
// monitor as the DUT emits them.
module tb_pwm_capture;

  localparam int DIV    = 4;
  localparam int WIDTH  = 5;
  localparam int PERIOD = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             pwm_in = 1'b0;
  logic [WIDTH-1:0] duty_out;
  logic             duty_valid, frame_err, stuck_high, locked;

  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] duty;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails = 0;
  int   pending = -1;  // -1: nothing to close, -2: short frame, else duty

  pwm_capture #(.DIV(DIV), .WIDTH(WIDTH), .PERIOD(PERIOD)) dut (
    .clk(clk), .reset(reset), .pwm_in(pwm_in), .duty_out(duty_out),
    .duty_valid(duty_valid), .frame_err(frame_err),
    .stuck_high(stuck_high), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Hold pwm_in at v for exactly one sample tick (DIV clocks).
  task automatic tick_drive(input logic v);
    @(negedge clk);
    pwm_in = v;
    repeat (DIV - 1) @(negedge clk);
  endtask

  task automatic push(input logic err, input int duty);
    exp_t e;
    e.err  = err;
    e.duty = WIDTH'(duty);
    exp_q.push_back(e);
  endtask

  // The leading edge of a new high period closes the previous frame.
  task automatic close_prev();
    if (pending >= 0) push(1'b0, pending);
    else if (pending == -2) push(1'b1, 0);
  endtask

  task automatic frame(input int r, input int len);
    close_prev();
    for (int i = 0; i < len; i++) tick_drive(i < r);
    pending = (len == PERIOD) ? r : -2;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_duty_out"}, 32'(duty_out), 0);
    check({tag, "_duty_valid"}, 32'(duty_valid), 0);
    check({tag, "_frame_err"}, 32'(frame_err), 0);
    check({tag, "_stuck_high"}, 32'(stuck_high), 0);
    check({tag, "_locked"}, 32'(locked), 0);
  endtask

  // Monitor: every pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (duty_valid || frame_err) begin
      if (duty_valid && frame_err) check("valid_and_err_together", 1, 0);
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_pulse: got valid=%0b err=%0b duty=%0d, expected no pulse",
                 duty_valid, frame_err, duty_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_is_err", 32'(frame_err), 32'(e.err));
        if (!e.err) check("duty_out", 32'(duty_out), 32'(e.duty));
      end
    end
  end

  initial begin
    // Reset while the input toggles
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pwm_in = ~pwm_in;
    end
    check_idle("reset");
    pwm_in = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) tick_drive(1'b0);
    check("idle_locked", 32'(locked), 0);

    // First edge locks without a pulse, then steady ref=13
    frame(13, PERIOD);
    check("first_frame_locked", 32'(locked), 1);
    frame(13, PERIOD);
    frame(13, PERIOD);

    // Back-to-back sweep of every legal nonzero reference
    for (int r = 1; r < PERIOD; r++) frame(r, PERIOD);

    // Input stuck high: edge closes the 31 frame, then a stuck timeout
    close_prev();
    push(1'b1, 0);
    pending = -1;
    for (int i = 0; i < 80; i++) tick_drive(1'b1);
    check("stuck_set", 32'(stuck_high), 1);
    check("stuck_locked", 32'(locked), 0);
    check("stuck_duty_held", 32'(duty_out), 31);

    // Constant low: duty 0 reported once per two frames
    push(1'b0, 0);
    push(1'b0, 0);
    for (int i = 0; i < 150; i++) tick_drive(1'b0);
    check("low_duty_zero", 32'(duty_out), 0);
    check("low_locked", 32'(locked), 0);
    check("low_stuck_kept", 32'(stuck_high), 1);

    // Short 30-tick frame; its leading edge clears stuck_high
    frame(10, 30);
    check("edge_clears_stuck", 32'(stuck_high), 0);
    check("short_locked", 32'(locked), 1);

    // Next edge rejects the short frame, then reset aborts the new one
    close_prev();
    pending = -1;
    for (int i = 0; i < 15; i++) tick_drive(1'b1);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check_idle("midreset");
    pwm_in = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 40; i++) tick_drive(1'b0);
    check_idle("after_reset");

    repeat (20) @(negedge clk);
    check("all_expected_pulses_seen", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
